xif_coproc_arbiter: RTL and testbench
=====================================

// Module: xif_coproc_arbiter
// PURPOSE
//  Shares one core-side CORE-V-X-IF (issue/commit/result subset) between NUM_CP coprocessors.
//  - Broadcasts issue requests to all coprocessors and records which one accepted each in-flight ID.
//  - Routes commit/kill only to the owning coprocessor.
//  - Round-robin arbitrates coprocessor results into a registered result stage towards the core.
//  - Sits between the core's eXtension interface and the coprocessor instances.
// PARAMETERS
//  NUM_CP          2   number of coprocessors (1..8)
//  X_ID_WIDTH      4   instruction ID width; owner table has 2**X_ID_WIDTH entries
//  XLEN            32  result data width
//  MAX_OUTSTANDING 4   max accepted, unretired instructions (1..2**X_ID_WIDTH)
// PORTS
//  clk_i              in   1               clock
//  rst_ni             in   1               async reset, active low
//  issue_valid_i      in   1               core issue request valid
//  issue_ready_o      out  1               issue handshake ready
//  issue_instr_i      in   32              offloaded instruction
//  issue_id_i         in   X_ID_WIDTH      instruction ID
//  issue_accept_o     out  1               some coprocessor accepted
//  issue_writeback_o  out  1               writeback flag of accepting coprocessor
//  commit_valid_i     in   1               commit strobe
//  commit_id_i        in   X_ID_WIDTH      committed/killed ID
//  commit_kill_i      in   1               kill (1) or commit (0)
//  result_valid_o     out  1               result to core valid
//  result_ready_i     in   1               core accepts result
//  result_id_o        out  X_ID_WIDTH      result ID
//  result_data_o      out  XLEN            result data
//  result_rd_o        out  5               destination register
//  result_we_o        out  1               register write enable
//  accept_conflict_o  out  1               sticky: >1 coprocessor accepted one issue
//  cp_issue_valid_o   out  NUM_CP          per-CP issue valid
//  cp_issue_ready_i   in   NUM_CP          per-CP issue ready
//  cp_issue_accept_i  in   NUM_CP          per-CP accept
//  cp_issue_wb_i      in   NUM_CP          per-CP writeback flag
//  cp_issue_instr_o   out  32              broadcast instruction
//  cp_issue_id_o      out  X_ID_WIDTH      broadcast ID
//  cp_commit_valid_o  out  NUM_CP          one-hot commit to owner
//  cp_commit_id_o     out  X_ID_WIDTH      commit ID
//  cp_commit_kill_o   out  1               kill flag
//  cp_result_valid_i  in   NUM_CP          per-CP result valid
//  cp_result_ready_o  out  NUM_CP          per-CP result ready (one-hot grant)
//  cp_result_id_i     in   NUM_CP*X_ID_WIDTH  packed IDs, CP0 in LSBs
//  cp_result_data_i   in   NUM_CP*XLEN     packed data
//  cp_result_rd_i     in   NUM_CP*5        packed rd
//  cp_result_we_i     in   NUM_CP          per-CP we
// BEHAVIOUR
//  Clock/reset: single clock clk_i; rst_ni async active-low. Reset clears the owner table, count=0,
//   rr_ptr=0, result stage empty (result_* outputs 0) and accept_conflict_o=0.
//  Issue path (combinational, 0 cycles):
//   - stall = (count==MAX_OUTSTANDING) | table[issue_id_i].valid
//   - cp_issue_valid_o[i] = issue_valid_i & ~stall
//   - issue_ready_o = ~stall & (&cp_issue_ready_i)
//   - cp_issue_instr_o/cp_issue_id_o pass issue_instr_i/issue_id_i through.
//  Issue handshake (issue_valid_i & issue_ready_o):
//   - Owner = lowest index with accept=1; issue_accept_o=|accept; issue_writeback_o=cp_issue_wb_i[owner].
//   - On accept: table[id] <= {valid=1, owner}; count+1.
//   - No accept: no entry, count unchanged.
//   - >1 accept: accept_conflict_o <= 1 (sticky until reset).
//  Commit path (combinational):
//   - cp_commit_valid_o = onehot(owner) when commit_valid_i and entry valid; else 0.
//   - Same-cycle issue+commit of the same ID bypasses to the accepting CP.
//   - cp_commit_id_o/cp_commit_kill_o pass through.
//   - Kill frees the entry at the clock edge (count-1). Commit leaves the entry allocated.
//  Result arbitration:
//   - Stage loads when empty or (result_valid_o & result_ready_i).
//   - Grant: first valid CP at/after rr_ptr (wrapping), ANDed with load; cp_result_ready_o=onehot(grant).
//   - Granted result reaches result_*_o the next cycle (1-cycle latency).
//   - rr_ptr <= grant+1 mod NUM_CP.
//  Stale results:
//   - A granted result whose ID has no valid entry (killed) is consumed from the CP and dropped.
//   - Stage is not loaded.
//  Retire: the core result handshake frees table[result_id_o] (count-1).
//  Simultaneous events:
//   - One alloc plus one free in the same cycle: count unchanged.
//   - Kill and a result grant for the same ID in one cycle: kill wins and the result is dropped.
//   - Kill + retire of two IDs in one cycle: count-2.
//   - count never exceeds MAX_OUTSTANDING or underflows (assertions).
//  Stage full with result_ready_i=0: all cp_result_ready_o=0 and result_*_o held stable.
// TESTING
//  1. NUM_CP=2; CP1 accepts id 3 -> issue_accept_o=1, owner=1; commit id3 -> cp_commit_valid_o=2'b10.
//  2. CP0 and CP1 results valid every cycle, ready_i=1 -> grants alternate 01,10,01; rr wraps.
//  3. Four IDs 0..3 accepted -> issue_ready_o=0 on 5th; retire id0 -> ready returns next cycle.
//  4. Issue id5 to CP0, kill id5, CP0 presents id5 result -> cp_result_ready_o[0]=1, result_valid_o stays 0.
//  5. Both CPs accept id2 -> owner=CP0, accept_conflict_o=1 until rst_ni low.
//  6. result_ready_i=0 for 3 cycles with stage full -> result_data_o stable, cp_result_ready_o=0; reset mid-burst -> all outputs 0.

Source files
------------

// File: rtl/xif_coproc_arbiter.sv
// Shares one core-side eXtension interface (issue/commit/result) between NUM_CP coprocessors.
// Tracks the owner of every in-flight ID and round-robins coprocessor results into one output stage.
module xif_coproc_arbiter #(
    parameter int NUM_CP          = 2,
    parameter int X_ID_WIDTH      = 4,
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         issue_valid_i,
    output logic                         issue_ready_o,
    input  logic [31:0]                  issue_instr_i,
    input  logic [X_ID_WIDTH-1:0]        issue_id_i,
    output logic                         issue_accept_o,
    output logic                         issue_writeback_o,
    input  logic                         commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]        commit_id_i,
    input  logic                         commit_kill_i,
    output logic                         result_valid_o,
    input  logic                         result_ready_i,
    output logic [X_ID_WIDTH-1:0]        result_id_o,
    output logic [XLEN-1:0]              result_data_o,
    output logic [4:0]                   result_rd_o,
    output logic                         result_we_o,
    output logic                         accept_conflict_o,
    output logic [NUM_CP-1:0]            cp_issue_valid_o,
    input  logic [NUM_CP-1:0]            cp_issue_ready_i,
    input  logic [NUM_CP-1:0]            cp_issue_accept_i,
    input  logic [NUM_CP-1:0]            cp_issue_wb_i,
    output logic [31:0]                  cp_issue_instr_o,
    output logic [X_ID_WIDTH-1:0]        cp_issue_id_o,
    output logic [NUM_CP-1:0]            cp_commit_valid_o,
    output logic [X_ID_WIDTH-1:0]        cp_commit_id_o,
    output logic                         cp_commit_kill_o,
    input  logic [NUM_CP-1:0]            cp_result_valid_i,
    output logic [NUM_CP-1:0]            cp_result_ready_o,
    input  logic [NUM_CP*X_ID_WIDTH-1:0] cp_result_id_i,
    input  logic [NUM_CP*XLEN-1:0]       cp_result_data_i,
    input  logic [NUM_CP*5-1:0]          cp_result_rd_i,
    input  logic [NUM_CP-1:0]            cp_result_we_i
);

    localparam int NUM_IDS = 2 ** X_ID_WIDTH;
    localparam int OW      = (NUM_CP > 1) ? $clog2(NUM_CP) : 1;
    localparam int CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [NUM_IDS-1:0]    tbl_valid;
    logic [OW-1:0]         tbl_owner [NUM_IDS];
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic [OW-1:0]         rr_ptr;

    logic                  res_valid;
    logic [X_ID_WIDTH-1:0] res_id;
    logic [XLEN-1:0]       res_data;
    logic [4:0]            res_rd;
    logic                  res_we;
    logic                  conflict;

    logic                  stall;
    logic                  issue_hs;
    logic                  iss_found;
    logic [OW-1:0]         iss_owner;
    logic                  multi_accept;
    logic                  alloc;
    logic                  alloc_eff;

    logic                  cmt_hit_tbl;
    logic                  cmt_hit_byp;
    logic [OW-1:0]         cmt_owner;
    logic                  kill_tbl;
    logic                  kill_byp;

    logic                  load;
    logic                  grant_found;
    logic                  grant_valid;
    logic [OW-1:0]         grant_idx;
    logic [X_ID_WIDTH-1:0] g_id;
    logic                  g_live;
    logic                  stage_load;
    logic                  ret_hs;
    logic                  ret_free;

    always_comb begin
        stall             = (count == MAX_CNT) | tbl_valid[issue_id_i];
        issue_ready_o     = ~stall & (&cp_issue_ready_i);
        cp_issue_valid_o  = {NUM_CP{issue_valid_i & ~stall}};
        cp_issue_instr_o  = issue_instr_i;
        cp_issue_id_o     = issue_id_i;
        issue_hs          = issue_valid_i & issue_ready_o;

        iss_found = 1'b0;
        iss_owner = '0;
        for (int i = 0; i < NUM_CP; i++) begin
            if (cp_issue_accept_i[i] && !iss_found) begin
                iss_found = 1'b1;
                iss_owner = OW'(i);
            end
        end
        multi_accept      = |(cp_issue_accept_i & (cp_issue_accept_i - NUM_CP'(1)));
        issue_accept_o    = issue_hs & iss_found;
        issue_writeback_o = issue_accept_o & cp_issue_wb_i[iss_owner];
        alloc             = issue_accept_o;

        // A commit for an ID being accepted this very cycle is steered to the accepting CP.
        cmt_hit_tbl       = commit_valid_i & tbl_valid[commit_id_i];
        cmt_hit_byp       = commit_valid_i & alloc & (issue_id_i == commit_id_i);
        cmt_owner         = cmt_hit_byp ? iss_owner : tbl_owner[commit_id_i];
        cp_commit_valid_o = '0;
        if (cmt_hit_tbl | cmt_hit_byp) begin
            cp_commit_valid_o[cmt_owner] = 1'b1;
        end
        cp_commit_id_o    = commit_id_i;
        cp_commit_kill_o  = commit_kill_i;
        kill_tbl          = cmt_hit_tbl & commit_kill_i;
        kill_byp          = cmt_hit_byp & commit_kill_i;
        alloc_eff         = alloc & ~kill_byp;
    end

    always_comb begin
        load        = ~res_valid | result_ready_i;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_CP; k++) begin
            if (!grant_found && cp_result_valid_i[(int'(rr_ptr) + k) % NUM_CP]) begin
                grant_found = 1'b1;
                grant_idx   = OW'((int'(rr_ptr) + k) % NUM_CP);
            end
        end
        grant_valid       = load & grant_found;
        cp_result_ready_o = '0;
        if (grant_valid) begin
            cp_result_ready_o[grant_idx] = 1'b1;
        end

        // Results for killed IDs are still consumed from the CP but never reach the core.
        g_id       = cp_result_id_i[int'(grant_idx)*X_ID_WIDTH +: X_ID_WIDTH];
        g_live     = tbl_valid[g_id] & ~(kill_tbl & (commit_id_i == g_id));
        stage_load = grant_valid & g_live;

        ret_hs     = res_valid & result_ready_i;
        ret_free   = ret_hs & tbl_valid[res_id] & ~(kill_tbl & (commit_id_i == res_id));

        count_next = count;
        if (alloc_eff) count_next = count_next + CW'(1);
        if (kill_tbl)  count_next = count_next - CW'(1);
        if (ret_free)  count_next = count_next - CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tbl_valid <= '0;
            for (int i = 0; i < NUM_IDS; i++) begin
                tbl_owner[i] <= '0;
            end
            count     <= '0;
            rr_ptr    <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
            res_rd    <= '0;
            res_we    <= 1'b0;
            conflict  <= 1'b0;
        end else begin
            if (alloc_eff) begin
                tbl_valid[issue_id_i] <= 1'b1;
                tbl_owner[issue_id_i] <= iss_owner;
            end
            if (kill_tbl) tbl_valid[commit_id_i] <= 1'b0;
            if (ret_free) tbl_valid[res_id] <= 1'b0;
            count <= count_next;
            if (grant_valid) begin
                rr_ptr <= (grant_idx == OW'(NUM_CP - 1)) ? '0 : grant_idx + OW'(1);
            end
            if (stage_load) begin
                res_valid <= 1'b1;
                res_id    <= g_id;
                res_data  <= cp_result_data_i[int'(grant_idx)*XLEN +: XLEN];
                res_rd    <= cp_result_rd_i[int'(grant_idx)*5 +: 5];
                res_we    <= cp_result_we_i[grant_idx];
            end else if (ret_hs) begin
                res_valid <= 1'b0;
            end
            if (issue_hs && multi_accept) conflict <= 1'b1;
        end
    end

    assign result_valid_o    = res_valid;
    assign result_id_o       = res_id;
    assign result_data_o     = res_data;
    assign result_rd_o       = res_rd;
    assign result_we_o       = res_we;
    assign accept_conflict_o = conflict;

`ifndef SYNTHESIS
    a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni) count <= MAX_CNT);
    a_count_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (int'(count) + int'(alloc_eff)) >= (int'(kill_tbl) + int'(ret_free)));
`endif

endmodule

// File: tb/tb_xif_coproc_arbiter.sv
// Directed vector table plus hand-written multi-cycle sequences for xif_coproc_arbiter
// (NUM_CP=2, X_ID_WIDTH=4, XLEN=32, MAX_OUTSTANDING=4).
module tb_xif_coproc_arbiter;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_instr;
    logic [3:0]  issue_id;
    logic        issue_accept;
    logic        issue_writeback;
    logic        commit_valid;
    logic [3:0]  commit_id;
    logic        commit_kill;
    logic        result_valid;
    logic        result_ready;
    logic [3:0]  result_id;
    logic [31:0] result_data;
    logic [4:0]  result_rd;
    logic        result_we;
    logic        accept_conflict;
    logic [1:0]  cp_issue_valid;
    logic [1:0]  cp_issue_ready;
    logic [1:0]  cp_issue_accept;
    logic [1:0]  cp_issue_wb;
    logic [31:0] cp_issue_instr;
    logic [3:0]  cp_issue_id;
    logic [1:0]  cp_commit_valid;
    logic [3:0]  cp_commit_id;
    logic        cp_commit_kill;
    logic [1:0]  cp_result_valid;
    logic [1:0]  cp_result_ready;
    logic [7:0]  cp_result_id;
    logic [63:0] cp_result_data;
    logic [9:0]  cp_result_rd;
    logic [1:0]  cp_result_we;

    int n_compared = 0;
    int n_mismatched = 0;

    xif_coproc_arbiter #(
        .NUM_CP(2), .X_ID_WIDTH(4), .XLEN(32), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .issue_instr_i(issue_instr), .issue_id_i(issue_id),
        .issue_accept_o(issue_accept), .issue_writeback_o(issue_writeback),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .result_valid_o(result_valid), .result_ready_i(result_ready),
        .result_id_o(result_id), .result_data_o(result_data),
        .result_rd_o(result_rd), .result_we_o(result_we),
        .accept_conflict_o(accept_conflict),
        .cp_issue_valid_o(cp_issue_valid), .cp_issue_ready_i(cp_issue_ready),
        .cp_issue_accept_i(cp_issue_accept), .cp_issue_wb_i(cp_issue_wb),
        .cp_issue_instr_o(cp_issue_instr), .cp_issue_id_o(cp_issue_id),
        .cp_commit_valid_o(cp_commit_valid), .cp_commit_id_o(cp_commit_id),
        .cp_commit_kill_o(cp_commit_kill),
        .cp_result_valid_i(cp_result_valid), .cp_result_ready_o(cp_result_ready),
        .cp_result_id_i(cp_result_id), .cp_result_data_i(cp_result_data),
        .cp_result_rd_i(cp_result_rd), .cp_result_we_i(cp_result_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic       issue_valid;
        logic [3:0] issue_id;
        logic [1:0] cp_ready;
        logic [1:0] cp_accept;
        logic [1:0] cp_wb;
        logic       commit_valid;
        logic [3:0] commit_id;
        logic       commit_kill;
        logic       exp_ready;
        logic       exp_accept;
        logic       exp_wb;
        logic [1:0] exp_commit;
    } vec_t;

    vec_t vecs [13];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        issue_valid     = 1'b0;
        issue_instr     = 32'h0000_0000;
        issue_id        = 4'd0;
        cp_issue_ready  = 2'b11;
        cp_issue_accept = 2'b00;
        cp_issue_wb     = 2'b00;
        commit_valid    = 1'b0;
        commit_id       = 4'd0;
        commit_kill     = 1'b0;
        result_ready    = 1'b1;
        cp_result_valid = 2'b00;
        cp_result_id    = 8'h00;
        cp_result_data  = 64'h0;
        cp_result_rd    = 10'h0;
        cp_result_we    = 2'b00;
    endtask

    task automatic applyStimulus(input vec_t v);
        issue_valid     = v.issue_valid;
        issue_id        = v.issue_id;
        issue_instr     = {28'h00000AB, v.issue_id};
        cp_issue_ready  = v.cp_ready;
        cp_issue_accept = v.cp_accept;
        cp_issue_wb     = v.cp_wb;
        commit_valid    = v.commit_valid;
        commit_id       = v.commit_id;
        commit_kill     = v.commit_kill;
    endtask

    task automatic doReset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issueOne(input logic [3:0] id, input logic [1:0] acc);
        @(negedge clk);
        idle();
        issue_valid     = 1'b1;
        issue_id        = id;
        cp_issue_accept = acc;
    endtask

    initial begin
        // Issue/commit path vectors, applied back to back from reset (state accumulates).
        vecs[0]  = '{1'b1, 4'd3, 2'b11, 2'b10, 2'b10, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00};
        vecs[1]  = '{1'b0, 4'd0, 2'b11, 2'b00, 2'b00, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10};
        vecs[2]  = '{1'b1, 4'd3, 2'b11, 2'b01, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[3]  = '{1'b1, 4'd0, 2'b11, 2'b01, 2'b00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01};
        vecs[4]  = '{1'b1, 4'd1, 2'b01, 2'b01, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[5]  = '{1'b1, 4'd1, 2'b11, 2'b01, 2'b00, 1'b1, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00};
        vecs[6]  = '{1'b1, 4'd2, 2'b11, 2'b11, 2'b10, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00};
        vecs[7]  = '{1'b1, 4'd5, 2'b11, 2'b00, 2'b00, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01};
        vecs[8]  = '{1'b1, 4'd5, 2'b11, 2'b00, 2'b00, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
        vecs[9]  = '{1'b1, 4'd5, 2'b11, 2'b01, 2'b00, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01};
        vecs[10] = '{1'b1, 4'd6, 2'b11, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[11] = '{1'b1, 4'd6, 2'b11, 2'b10, 2'b10, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00};
        vecs[12] = '{1'b1, 4'd7, 2'b11, 2'b00, 2'b00, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

        idle();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("reset.result_valid", 32'(result_valid), 32'd0);
        checkOutput("reset.result_data", result_data, 32'd0);
        checkOutput("reset.result_id", 32'(result_id), 32'd0);
        checkOutput("reset.conflict", 32'(accept_conflict), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            idle();
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d.issue_ready", i), 32'(issue_ready), 32'(vecs[i].exp_ready));
            checkOutput($sformatf("v%0d.issue_accept", i), 32'(issue_accept), 32'(vecs[i].exp_accept));
            checkOutput($sformatf("v%0d.issue_wb", i), 32'(issue_writeback), 32'(vecs[i].exp_wb));
            checkOutput($sformatf("v%0d.commit_valid", i), 32'(cp_commit_valid), 32'(vecs[i].exp_commit));
        end
        checkOutput("v.cp_issue_id", 32'(cp_issue_id), 32'd7);
        checkOutput("v.cp_issue_instr", cp_issue_instr, 32'h0000_0AB7);
        checkOutput("v.conflict_sticky", 32'(accept_conflict), 32'd1);

        // Table full (ids 0,1,2,6): retire id0 and watch issue ready come back.
        @(negedge clk);
        idle();
        cp_result_valid = 2'b01;
        cp_result_id    = 8'h00;
        cp_result_data  = 64'h0000_0000_AAAA_0000;
        cp_result_rd    = 10'd5;
        cp_result_we    = 2'b01;
        #1;
        checkOutput("retire.grant", 32'(cp_result_ready), 32'h1);
        @(negedge clk);
        idle();
        issue_valid = 1'b1;
        issue_id    = 4'd7;
        #1;
        checkOutput("retire.result_valid", 32'(result_valid), 32'd1);
        checkOutput("retire.result_data", result_data, 32'hAAAA_0000);
        checkOutput("retire.result_rd", 32'(result_rd), 32'd5);
        checkOutput("retire.result_we", 32'(result_we), 32'd1);
        checkOutput("retire.full_ready", 32'(issue_ready), 32'd0);
        checkOutput("retire.full_cp_valid", 32'(cp_issue_valid), 32'h0);
        @(negedge clk);
        #1;
        checkOutput("retire.ready_back", 32'(issue_ready), 32'd1);
        checkOutput("retire.cp_valid_back", 32'(cp_issue_valid), 32'h3);
        checkOutput("retire.stage_empty", 32'(result_valid), 32'd0);

        // Killed IDs: result consumed but dropped, including kill and grant in one cycle.
        doReset();
        issueOne(4'd5, 2'b01);
        @(negedge clk);
        idle();
        commit_valid = 1'b1;
        commit_id    = 4'd5;
        commit_kill  = 1'b1;
        #1;
        checkOutput("stale.kill_route", 32'(cp_commit_valid), 32'h1);
        @(negedge clk);
        idle();
        cp_result_valid = 2'b01;
        cp_result_id    = 8'h05;
        cp_result_data  = 64'h0000_0000_DEAD_0005;
        #1;
        checkOutput("stale.grant", 32'(cp_result_ready), 32'h1);
        @(negedge clk);
        idle();
        #1;
        checkOutput("stale.dropped", 32'(result_valid), 32'd0);
        issueOne(4'd9, 2'b10);
        @(negedge clk);
        idle();
        commit_valid    = 1'b1;
        commit_id       = 4'd9;
        commit_kill     = 1'b1;
        cp_result_valid = 2'b10;
        cp_result_id    = 8'h90;
        #1;
        checkOutput("stale.same_cycle_grant", 32'(cp_result_ready), 32'h2);
        @(negedge clk);
        idle();
        #1;
        checkOutput("stale.same_cycle_dropped", 32'(result_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            issueOne(4'(i), 2'b01);
            #1;
            checkOutput($sformatf("stale.refill%0d", i), 32'(issue_accept), 32'd1);
        end
        issueOne(4'd4, 2'b01);
        #1;
        checkOutput("stale.refill_full", 32'(issue_ready), 32'd0);

        // Round-robin alternation with both CPs permanently valid.
        doReset();
        issueOne(4'd1, 2'b01);
        issueOne(4'd2, 2'b10);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle();
            cp_result_valid = 2'b11;
            cp_result_id    = {4'd2, 4'd1};
            cp_result_data  = {32'h2222_0000, 32'h1111_0000};
            cp_result_rd    = {5'd2, 5'd1};
            cp_result_we    = 2'b11;
            #1;
            checkOutput($sformatf("rr.grant%0d", c), 32'(cp_result_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
            if (c == 1) begin
                checkOutput("rr.out1_id", 32'(result_id), 32'd1);
                checkOutput("rr.out1_data", result_data, 32'h1111_0000);
            end
            if (c == 2) begin
                checkOutput("rr.out2_id", 32'(result_id), 32'd2);
                checkOutput("rr.out2_data", result_data, 32'h2222_0000);
            end
            if (c == 3) checkOutput("rr.out3_valid", 32'(result_valid), 32'd0);
        end

        // Conflict flag, back-pressure hold, then reset mid-burst.
        doReset();
        issueOne(4'd2, 2'b11);
        #1;
        checkOutput("conf.owner_cp0", 32'(issue_accept), 32'd1);
        checkOutput("conf.before_edge", 32'(accept_conflict), 32'd0);
        issueOne(4'd4, 2'b10);
        #1;
        checkOutput("conf.set", 32'(accept_conflict), 32'd1);
        @(negedge clk);
        idle();
        commit_valid = 1'b1;
        commit_id    = 4'd2;
        result_ready = 1'b0;
        cp_result_valid = 2'b10;
        cp_result_id    = {4'd4, 4'd2};
        cp_result_data  = {32'h1234_5678, 32'h0BAD_0002};
        cp_result_rd    = {5'd9, 5'd3};
        cp_result_we    = 2'b10;
        #1;
        checkOutput("conf.commit_owner", 32'(cp_commit_valid), 32'h1);
        checkOutput("hold.first_grant", 32'(cp_result_ready), 32'h2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            commit_valid    = 1'b0;
            cp_result_valid = 2'b11;
            #1;
            checkOutput($sformatf("hold%0d.grant", c), 32'(cp_result_ready), 32'h0);
            checkOutput($sformatf("hold%0d.data", c), result_data, 32'h1234_5678);
            checkOutput($sformatf("hold%0d.rd", c), 32'(result_rd), 32'd9);
            checkOutput($sformatf("hold%0d.valid", c), 32'(result_valid), 32'd1);
        end
        checkOutput("conf.still_set", 32'(accept_conflict), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset.valid", 32'(result_valid), 32'd0);
        checkOutput("midreset.data", result_data, 32'd0);
        checkOutput("midreset.id", 32'(result_id), 32'd0);
        checkOutput("midreset.rd", 32'(result_rd), 32'd0);
        checkOutput("midreset.we", 32'(result_we), 32'd0);
        checkOutput("midreset.conflict", 32'(accept_conflict), 32'd0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
